// File: rtl/i2c_seq_pkg.sv
// Shared encodings for the I2C transaction sequencer: engine commands,
// completion status codes and sequencer FSM states.
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_START  = 3'd1,
        CMD_WRITE  = 3'd2,
        CMD_READ   = 3'd3,
        CMD_STOP   = 3'd4,
        CMD_RSTART = 3'd5
    } eng_cmd_e;

    typedef enum logic [1:0] {
        ERR_OK        = 2'b00,
        ERR_ADDR_NACK = 2'b01,
        ERR_DATA_NACK = 2'b10,
        ERR_TIMEOUT   = 2'b11
    } err_e;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_ADDR_W = 4'd2,
        ST_REG    = 4'd3,
        ST_WDATA  = 4'd4,
        ST_RSTART = 4'd5,
        ST_ADDR_R = 4'd6,
        ST_RDATA  = 4'd7,
        ST_STOP   = 4'd8,
        ST_DONE   = 4'd9
    } state_e;

    // Engine command issued from each command-bearing state
    function automatic eng_cmd_e state_cmd(input state_e st);
        case (st)
            ST_START:                                 state_cmd = CMD_START;
            ST_ADDR_W, ST_REG, ST_WDATA, ST_ADDR_R:   state_cmd = CMD_WRITE;
            ST_RDATA:                                 state_cmd = CMD_READ;
            ST_STOP:                                  state_cmd = CMD_STOP;
            ST_RSTART:                                state_cmd = CMD_RSTART;
            default:                                  state_cmd = CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Two-way round-robin arbiter; the last-grant pointer resets to requester 1
// so requester 0 wins the first simultaneous request.
module i2c_rr_arbiter (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic arb_en,
    input  logic req0,
    input  logic req1,
    output logic gnt_valid,
    output logic gnt_id
);

    logic last_r;
    logic gnt_id_s;

    // Winner selection: on a tie, the requester not granted last
    always_comb begin
        gnt_id_s = 1'b0;
        if (req0 && req1) begin
            gnt_id_s = ~last_r;
        end else if (req1) begin
            gnt_id_s = 1'b1;
        end else begin
            gnt_id_s = 1'b0;
        end
    end

    assign gnt_valid = arb_en && (req0 || req1);
    assign gnt_id    = gnt_id_s;

    // Last-grant pointer
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            last_r <= 1'b1;
        end else if (gnt_valid) begin
            last_r <= gnt_id_s;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Transaction-level I2C sequencer: arbitrates two requesters and drives the
// byte-level engine through START/addr/reg/data/RSTART/STOP command sequences.
module i2c_txn_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [6:0]       req0_addr,
    input  logic             req0_rw,
    input  logic [7:0]       req0_reg,
    input  logic [LEN_W-1:0] req0_len,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [6:0]       req1_addr,
    input  logic             req1_rw,
    input  logic [7:0]       req1_reg,
    input  logic [LEN_W-1:0] req1_len,
    output logic             gnt_id,
    output logic             busy,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic [1:0]       err,
    output logic [2:0]       eng_cmd,
    output logic             eng_valid,
    input  logic             eng_ready,
    output logic [7:0]       eng_tx,
    output logic             eng_ack_tx,
    input  logic             eng_done,
    input  logic             eng_ack_rx,
    input  logic [7:0]       eng_rx
);

    localparam int               TMO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

    state_e           state_r, state_s;
    logic             wait_r, wait_s;
    logic [LEN_W-1:0] cnt_r, cnt_s, cnt_dec_s;
    logic [TMO_W-1:0] tmo_r, tmo_s;
    logic [6:0]       addr_r, addr_s;
    logic             rw_r, rw_s;
    logic [7:0]       reg_r, reg_s;
    err_e             pend_err_r, pend_err_s;
    logic             req0_ready_r, req0_ready_s, req1_ready_r, req1_ready_s;
    logic             gnt_id_r, gnt_id_s, busy_r, busy_s;
    logic             wr_ready_r, wr_ready_s, rd_valid_r, rd_valid_s;
    logic [7:0]       rd_data_r, rd_data_s, eng_tx_r, eng_tx_s;
    logic             done_r, done_s;
    err_e             err_r, err_s;
    eng_cmd_e         eng_cmd_r, eng_cmd_s;
    logic             eng_valid_r, eng_valid_s, eng_ack_tx_r, eng_ack_tx_s;
    logic             arb_valid_s, arb_id_s;

    i2c_rr_arbiter u_arb (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .arb_en    (state_r == ST_IDLE),
        .req0      (req0_valid),
        .req1      (req1_valid),
        .gnt_valid (arb_valid_s),
        .gnt_id    (arb_id_s)
    );

    assign cnt_dec_s = (cnt_r != {LEN_W{1'b0}}) ? (cnt_r - LEN_W'(1)) : {LEN_W{1'b0}};

    // Next-state and next-output logic for the transaction sequencer
    always_comb begin
        state_s      = state_r;
        wait_s       = wait_r;
        cnt_s        = cnt_r;
        tmo_s        = tmo_r;
        addr_s       = addr_r;
        rw_s         = rw_r;
        reg_s        = reg_r;
        pend_err_s   = pend_err_r;
        req0_ready_s = 1'b0;
        req1_ready_s = 1'b0;
        gnt_id_s     = gnt_id_r;
        busy_s       = busy_r;
        wr_ready_s   = 1'b0;
        rd_valid_s   = 1'b0;
        rd_data_s    = rd_data_r;
        done_s       = 1'b0;
        err_s        = ERR_OK;
        eng_cmd_s    = eng_cmd_r;
        eng_valid_s  = eng_valid_r;
        eng_tx_s     = eng_tx_r;
        eng_ack_tx_s = eng_ack_tx_r;

        // Timeout counter only advances while a command is outstanding
        if ((eng_valid_r || wait_r) && (tmo_r != TMO_MAX)) begin
            tmo_s = tmo_r + TMO_W'(1);
        end else begin
            tmo_s = tmo_r;
        end

        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
                wait_s = 1'b0;
                if (arb_valid_s) begin
                    if (arb_id_s) begin
                        req1_ready_s = 1'b1;
                        addr_s       = req1_addr;
                        rw_s         = req1_rw;
                        reg_s        = req1_reg;
                        cnt_s        = req1_len;
                    end else begin
                        req0_ready_s = 1'b1;
                        addr_s       = req0_addr;
                        rw_s         = req0_rw;
                        reg_s        = req0_reg;
                        cnt_s        = req0_len;
                    end
                    gnt_id_s   = arb_id_s;
                    pend_err_s = ERR_OK;
                    state_s    = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DONE: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            ST_START, ST_ADDR_W, ST_REG, ST_WDATA,
            ST_RSTART, ST_ADDR_R, ST_RDATA, ST_STOP: begin
                busy_s = 1'b1;
                if (!wait_r && !eng_valid_r) begin
                    // Write data stalls here without a timeout until wr_valid
                    if ((state_r != ST_WDATA) || wr_valid) begin
                        eng_valid_s = 1'b1;
                        eng_cmd_s   = state_cmd(state_r);
                        tmo_s       = {TMO_W{1'b0}};
                        case (state_r)
                            ST_ADDR_W: eng_tx_s = {addr_r, 1'b0};
                            ST_REG:    eng_tx_s = reg_r;
                            ST_WDATA:  eng_tx_s = wr_data;
                            ST_ADDR_R: eng_tx_s = {addr_r, 1'b1};
                            default:   eng_tx_s = 8'h00;
                        endcase
                        eng_ack_tx_s = (state_r == ST_RDATA) ? (cnt_r <= LEN_W'(1)) : 1'b1;
                    end else begin
                        eng_valid_s = 1'b0;
                    end
                end else if (wait_r && eng_done) begin
                    wait_s = 1'b0;
                    case (state_r)
                        ST_START:  state_s = ST_ADDR_W;
                        ST_ADDR_W: begin
                            if (eng_ack_rx) begin
                                pend_err_s = ERR_ADDR_NACK;
                                state_s    = ST_STOP;
                            end else begin
                                state_s = ST_REG;
                            end
                        end
                        ST_REG: begin
                            if (eng_ack_rx) begin
                                pend_err_s = ERR_DATA_NACK;
                                state_s    = ST_STOP;
                            end else if (cnt_r == {LEN_W{1'b0}}) begin
                                state_s = ST_STOP;
                            end else if (rw_r) begin
                                state_s = ST_RSTART;
                            end else begin
                                state_s = ST_WDATA;
                            end
                        end
                        ST_WDATA: begin
                            cnt_s = cnt_dec_s;
                            if (eng_ack_rx) begin
                                pend_err_s = ERR_DATA_NACK;
                                state_s    = ST_STOP;
                            end else if (cnt_r <= LEN_W'(1)) begin
                                state_s = ST_STOP;
                            end else begin
                                state_s = ST_WDATA;
                            end
                        end
                        ST_RSTART: state_s = ST_ADDR_R;
                        ST_ADDR_R: begin
                            if (eng_ack_rx) begin
                                pend_err_s = ERR_ADDR_NACK;
                                state_s    = ST_STOP;
                            end else begin
                                state_s = ST_RDATA;
                            end
                        end
                        ST_RDATA: begin
                            rd_valid_s = 1'b1;
                            rd_data_s  = eng_rx;
                            cnt_s      = cnt_dec_s;
                            state_s    = (cnt_r <= LEN_W'(1)) ? ST_STOP : ST_RDATA;
                        end
                        ST_STOP: begin
                            state_s = ST_DONE;
                            done_s  = 1'b1;
                            err_s   = pend_err_r;
                            busy_s  = 1'b0;
                        end
                        default: state_s = ST_IDLE;
                    endcase
                end else if (tmo_r == TMO_MAX) begin
                    // Abort straight to completion; the engine is left without STOP
                    eng_valid_s = 1'b0;
                    wait_s      = 1'b0;
                    state_s     = ST_DONE;
                    done_s      = 1'b1;
                    err_s       = ERR_TIMEOUT;
                    busy_s      = 1'b0;
                end else if (eng_valid_r && eng_ready) begin
                    eng_valid_s = 1'b0;
                    wait_s      = 1'b1;
                    wr_ready_s  = (state_r == ST_WDATA);
                end else begin
                    eng_valid_s = eng_valid_r;
                end
            end
            default: begin
                busy_s      = 1'b0;
                eng_valid_s = 1'b0;
                wait_s      = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, latched request fields and registered outputs
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_r      <= ST_IDLE;
            wait_r       <= 1'b0;
            cnt_r        <= {LEN_W{1'b0}};
            tmo_r        <= {TMO_W{1'b0}};
            addr_r       <= 7'h00;
            rw_r         <= 1'b0;
            reg_r        <= 8'h00;
            pend_err_r   <= ERR_OK;
            req0_ready_r <= 1'b0;
            req1_ready_r <= 1'b0;
            gnt_id_r     <= 1'b0;
            busy_r       <= 1'b0;
            wr_ready_r   <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_data_r    <= 8'h00;
            done_r       <= 1'b0;
            err_r        <= ERR_OK;
            eng_cmd_r    <= CMD_NONE;
            eng_valid_r  <= 1'b0;
            eng_tx_r     <= 8'h00;
            eng_ack_tx_r <= 1'b1;
        end else begin
            state_r      <= state_s;
            wait_r       <= wait_s;
            cnt_r        <= cnt_s;
            tmo_r        <= tmo_s;
            addr_r       <= addr_s;
            rw_r         <= rw_s;
            reg_r        <= reg_s;
            pend_err_r   <= pend_err_s;
            req0_ready_r <= req0_ready_s;
            req1_ready_r <= req1_ready_s;
            gnt_id_r     <= gnt_id_s;
            busy_r       <= busy_s;
            wr_ready_r   <= wr_ready_s;
            rd_valid_r   <= rd_valid_s;
            rd_data_r    <= rd_data_s;
            done_r       <= done_s;
            err_r        <= err_s;
            eng_cmd_r    <= eng_cmd_s;
            eng_valid_r  <= eng_valid_s;
            eng_tx_r     <= eng_tx_s;
            eng_ack_tx_r <= eng_ack_tx_s;
        end
    end

    assign req0_ready = req0_ready_r;
    assign req1_ready = req1_ready_r;
    assign gnt_id     = gnt_id_r;
    assign busy       = busy_r;
    assign wr_ready   = wr_ready_r;
    assign rd_valid   = rd_valid_r;
    assign rd_data    = rd_data_r;
    assign done       = done_r;
    assign err        = err_r;
    assign eng_cmd    = eng_cmd_r;
    assign eng_valid  = eng_valid_r;
    assign eng_tx     = eng_tx_r;
    assign eng_ack_tx = eng_ack_tx_r;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer with a behavioural engine/requester
// model; expected command streams are hand-written per scenario.
module tb_i2c_txn_sequencer;

    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 1023;

    logic             PCLK = 1'b0;
    logic             PRESETn = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [6:0]       req0_addr = 7'h00, req1_addr = 7'h00;
    logic             req0_rw = 1'b0, req1_rw = 1'b0;
    logic [7:0]       req0_reg = 8'h00, req1_reg = 8'h00;
    logic [LEN_W-1:0] req0_len = 4'd0, req1_len = 4'd0;
    logic             gnt_id, busy;
    logic [7:0]       wr_data = 8'h00;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [7:0]       rd_data;
    logic             rd_valid, done;
    logic [1:0]       err;
    logic [2:0]       eng_cmd;
    logic             eng_valid;
    logic             eng_ready = 1'b0;
    logic [7:0]       eng_tx;
    logic             eng_ack_tx;
    logic             eng_done = 1'b0, eng_ack_rx = 1'b0;
    logic [7:0]       eng_rx = 8'h00;

    i2c_txn_sequencer #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_rw(req0_rw), .req0_reg(req0_reg), .req0_len(req0_len),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_rw(req1_rw), .req1_reg(req1_reg), .req1_len(req1_len),
        .gnt_id(gnt_id), .busy(busy),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .eng_cmd(eng_cmd), .eng_valid(eng_valid), .eng_ready(eng_ready),
        .eng_tx(eng_tx), .eng_ack_tx(eng_ack_tx), .eng_done(eng_done),
        .eng_ack_rx(eng_ack_rx), .eng_rx(eng_rx)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    logic [11:0] cmd_log[$];
    logic [11:0] exp_q[$];
    logic [7:0]  rd_log[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  wr_q[$];
    logic        grant_log[$];
    int          wr_ready_cnt = 0;
    int          done_cnt = 0;
    logic [1:0]  last_err = 2'b00;
    logic        last_gnt = 1'b0;
    int          nack_idx = -1;
    bit          hold_done = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ent(input logic [2:0] c, input logic a, input logic [7:0] t);
        return {c, a, t};
    endfunction

    task automatic expect_cmd(input logic [2:0] c, input logic a, input logic [7:0] t);
        exp_q.push_back(ent(c, a, t));
    endtask

    task automatic check_log(input string tag);
        check_val({tag, "_ncmd"}, cmd_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < cmd_log.size()) begin
                check_val($sformatf("%s_cmd%0d", tag, i), cmd_log[i], exp_q[i]);
            end
        end
    endtask

    task automatic clear_logs();
        cmd_log.delete();
        exp_q.delete();
        rd_log.delete();
        wr_ready_cnt = 0;
    endtask

    task automatic start_req(input int id, input logic [6:0] a, input logic rw,
                             input logic [7:0] r, input logic [3:0] len);
        if (id == 0) begin
            req0_addr = a; req0_rw = rw; req0_reg = r; req0_len = len; req0_valid = 1'b1;
        end else begin
            req1_addr = a; req1_rw = rw; req1_reg = r; req1_len = len; req1_valid = 1'b1;
        end
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        int start;
        start = done_cnt;
        cycles = 0;
        while (done_cnt == start && cycles < budget) begin
            @(posedge PCLK); #1;
            cycles++;
        end
        check_val({tag, "_done_seen"}, (done_cnt != start), 32'd1);
    endtask

    // Engine, requester-handshake and output monitor, all on the falling edge
    initial begin
        bit         pend = 1'b0, seen = 1'b0;
        int         dly = 0, wcnt = 0, cur_widx = 0;
        logic [2:0] cur_cmd = 3'd0;
        forever begin
            @(negedge PCLK);
            eng_done = 1'b0;
            eng_ack_rx = 1'b0;
            if (!PRESETn) begin
                eng_ready = 1'b0; pend = 1'b0; seen = 1'b0; wcnt = 0;
            end else begin
                if (req0_ready) begin req0_valid = 1'b0; grant_log.push_back(1'b0); end
                if (req1_ready) begin req1_valid = 1'b0; grant_log.push_back(1'b1); end
                if (wr_ready) begin
                    wr_ready_cnt++;
                    if (wr_q.size() > 0) void'(wr_q.pop_front());
                end
                if (rd_valid) rd_log.push_back(rd_data);
                if (done) begin done_cnt++; last_err = err; last_gnt = gnt_id; wcnt = 0; end
                if (eng_ready) begin
                    eng_ready = 1'b0; pend = 1'b1; dly = 1;
                end else if (pend) begin
                    if (dly > 0) begin
                        dly--;
                    end else if (!hold_done) begin
                        eng_done = 1'b1;
                        pend = 1'b0;
                        eng_ack_rx = (cur_cmd == 3'd2) && (cur_widx == nack_idx);
                        if (cur_cmd == 3'd3 && rx_q.size() > 0) eng_rx = rx_q.pop_front();
                    end
                end else if (eng_valid) begin
                    if (!seen) begin
                        seen = 1'b1;
                    end else begin
                        seen = 1'b0;
                        cur_cmd = eng_cmd;
                        cmd_log.push_back(ent(eng_cmd, (eng_cmd == 3'd3) ? eng_ack_tx : 1'b0,
                                              (eng_cmd == 3'd2) ? eng_tx : 8'h00));
                        if (eng_cmd == 3'd2) begin cur_widx = wcnt; wcnt++; end
                        eng_ready = 1'b1;
                    end
                end
                wr_valid = (wr_q.size() > 0);
                wr_data  = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int dc;
        repeat (3) @(posedge PCLK);
        #1;
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_eng_valid", eng_valid, 1'b0);
        check_val("rst_eng_ack_tx", eng_ack_tx, 1'b1);
        check_val("rst_done", done, 1'b0);
        check_val("rst_req0_ready", req0_ready, 1'b0);
        check_val("rst_eng_cmd", eng_cmd, 3'd0);
        PRESETn = 1'b1;
        repeat (2) @(posedge PCLK); #1;

        // Write two bytes through requester 0
        clear_logs();
        wr_q.push_back(8'hA5); wr_q.push_back(8'h5A);
        start_req(0, 7'h10, 1'b0, 8'h03, 4'd2);
        repeat (5) @(posedge PCLK); #1;
        check_val("wr_busy", busy, 1'b1);
        wait_done("wr", 500, cyc);
        expect_cmd(3'd1, 1'b0, 8'h00); expect_cmd(3'd2, 1'b0, 8'h20);
        expect_cmd(3'd2, 1'b0, 8'h03); expect_cmd(3'd2, 1'b0, 8'hA5);
        expect_cmd(3'd2, 1'b0, 8'h5A); expect_cmd(3'd4, 1'b0, 8'h00);
        check_log("wr");
        check_val("wr_ready_pulses", wr_ready_cnt, 2);
        check_val("wr_err", last_err, 2'b00);
        check_val("wr_gnt", last_gnt, 1'b0);
        @(posedge PCLK); #1;
        check_val("wr_busy_after", busy, 1'b0);

        // Read two bytes through requester 1
        clear_logs();
        rx_q.push_back(8'hA5); rx_q.push_back(8'h5A);
        start_req(1, 7'h10, 1'b1, 8'h03, 4'd2);
        wait_done("rd", 500, cyc);
        expect_cmd(3'd1, 1'b0, 8'h00); expect_cmd(3'd2, 1'b0, 8'h20);
        expect_cmd(3'd2, 1'b0, 8'h03); expect_cmd(3'd5, 1'b0, 8'h00);
        expect_cmd(3'd2, 1'b0, 8'h21); expect_cmd(3'd3, 1'b0, 8'h00);
        expect_cmd(3'd3, 1'b1, 8'h00); expect_cmd(3'd4, 1'b0, 8'h00);
        check_log("rd");
        check_val("rd_nbytes", rd_log.size(), 2);
        if (rd_log.size() == 2) begin
            check_val("rd_byte0", rd_log[0], 8'hA5);
            check_val("rd_byte1", rd_log[1], 8'h5A);
        end
        check_val("rd_gnt", last_gnt, 1'b1);
        check_val("rd_err", last_err, 2'b00);
        repeat (2) @(posedge PCLK); #1;

        // Simultaneous requests, twice: round-robin order 0,1,0,1
        clear_logs();
        grant_log.delete();
        start_req(0, 7'h11, 1'b0, 8'h01, 4'd0);
        start_req(1, 7'h12, 1'b0, 8'h02, 4'd0);
        wait_done("arb_a", 500, cyc);
        wait_done("arb_b", 500, cyc);
        check_val("arb_ncmd", cmd_log.size(), 8);
        if (cmd_log.size() == 8) begin
            check_val("arb_addr0", cmd_log[1], ent(3'd2, 1'b0, 8'h22));
            check_val("arb_addr1", cmd_log[5], ent(3'd2, 1'b0, 8'h24));
            check_val("arb_reg1", cmd_log[6], ent(3'd2, 1'b0, 8'h02));
        end
        start_req(0, 7'h11, 1'b0, 8'h01, 4'd0);
        start_req(1, 7'h12, 1'b0, 8'h02, 4'd0);
        wait_done("arb_c", 500, cyc);
        wait_done("arb_d", 500, cyc);
        check_val("arb_ngrants", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            check_val("arb_g0", grant_log[0], 1'b0);
            check_val("arb_g1", grant_log[1], 1'b1);
            check_val("arb_g2", grant_log[2], 1'b0);
            check_val("arb_g3", grant_log[3], 1'b1);
        end
        repeat (2) @(posedge PCLK); #1;

        // Address NACK
        clear_logs();
        wr_q.delete(); wr_q.push_back(8'h11); wr_q.push_back(8'h22);
        nack_idx = 0;
        start_req(0, 7'h22, 1'b0, 8'h05, 4'd2);
        wait_done("anack", 500, cyc);
        expect_cmd(3'd1, 1'b0, 8'h00); expect_cmd(3'd2, 1'b0, 8'h44);
        expect_cmd(3'd4, 1'b0, 8'h00);
        check_log("anack");
        check_val("anack_err", last_err, 2'b01);
        check_val("anack_wr_ready", wr_ready_cnt, 0);

        // Register NACK
        clear_logs();
        wr_q.delete(); wr_q.push_back(8'h33);
        nack_idx = 1;
        start_req(0, 7'h10, 1'b0, 8'h20, 4'd1);
        wait_done("rnack", 500, cyc);
        expect_cmd(3'd1, 1'b0, 8'h00); expect_cmd(3'd2, 1'b0, 8'h20);
        expect_cmd(3'd2, 1'b0, 8'h20); expect_cmd(3'd4, 1'b0, 8'h00);
        check_log("rnack");
        check_val("rnack_err", last_err, 2'b10);
        check_val("rnack_wr_ready", wr_ready_cnt, 0);
        wr_q.delete();
        nack_idx = -1;
        repeat (2) @(posedge PCLK); #1;

        // Engine withholds eng_done: timeout abort, no STOP
        clear_logs();
        hold_done = 1'b1;
        start_req(0, 7'h10, 1'b0, 8'h00, 4'd0);
        wait_done("tmo", 3 * TIMEOUT, cyc);
        check_val("tmo_err", last_err, 2'b11);
        check_val("tmo_min_cycles", (cyc >= TIMEOUT), 1'b1);
        check_val("tmo_max_cycles", (cyc <= TIMEOUT + 30), 1'b1);
        repeat (20) @(posedge PCLK); #1;
        expect_cmd(3'd1, 1'b0, 8'h00);
        check_log("tmo");
        hold_done = 1'b0;
        repeat (5) @(posedge PCLK); #1;

        // Reset during the read data phase
        clear_logs();
        rx_q.delete();
        rx_q.push_back(8'h01); rx_q.push_back(8'h02); rx_q.push_back(8'h03);
        start_req(1, 7'h30, 1'b1, 8'h07, 4'd3);
        cyc = 0;
        while (rd_log.size() == 0 && cyc < 500) begin
            @(posedge PCLK); #1;
            cyc++;
        end
        check_val("rst_mid_rd_seen", (rd_log.size() != 0), 1'b1);
        dc = done_cnt;
        PRESETn = 1'b0;
        @(posedge PCLK); #1;
        check_val("rst_mid_busy", busy, 1'b0);
        check_val("rst_mid_eng_valid", eng_valid, 1'b0);
        check_val("rst_mid_ack_tx", eng_ack_tx, 1'b1);
        check_val("rst_mid_done", done, 1'b0);
        check_val("rst_mid_gnt", gnt_id, 1'b0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        rx_q.delete();
        repeat (5) @(posedge PCLK); #1;
        check_val("rst_mid_no_done", done_cnt, dc);
        clear_logs();
        grant_log.delete();
        start_req(0, 7'h10, 1'b0, 8'h03, 4'd0);
        wait_done("post_rst", 500, cyc);
        check_val("post_rst_ngrant", grant_log.size(), 1);
        if (grant_log.size() == 1) check_val("post_rst_gnt", grant_log[0], 1'b0);
        check_val("post_rst_err", last_err, 2'b00);
        expect_cmd(3'd1, 1'b0, 8'h00); expect_cmd(3'd2, 1'b0, 8'h20);
        expect_cmd(3'd2, 1'b0, 8'h03); expect_cmd(3'd4, 1'b0, 8'h00);
        check_log("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
